result_unloader: RTL and testbench
==================================

// Module: result_unloader
// PURPOSE
//  Return path of the watchdog core's pin interface. Captures the core's signed 32-bit result on
//  result_valid and sends it to the external host byte by byte on out_pins[7:0].
//  Each byte uses a four-phase out_valid/host_ack handshake. unloader_busy back-pressures the core.
//  Sits between the core's result port and the chip output pins.
// PARAMETERS
//  DATA_W       32  result width; must be a multiple of BYTE_W
//  BYTE_W       8   pin bus width
//  SYNC_STAGES  2   flops in the host_ack synchronizer (>=2)
// PORTS
//  clk            in   1       clock
//  rst_n          in   1       asynchronous, active-low reset
//  result         in   DATA_W  signed core result; sampled only when accepted
//  result_valid   in   1       one-cycle strobe from core
//  unloader_busy  out  1       transfer in progress; core must not strobe while high
//  out_pins       out  BYTE_W  current byte; stable while out_valid is high
//  out_valid      out  1       byte available to host
//  host_ack       in   1       asynchronous host acknowledge level
//  overrun        out  1       sticky: result_valid seen while busy
// BEHAVIOUR
//  - Reset: all outputs 0, state S_IDLE, shift register 0, byte_cnt 0, ack sync chain 0.
//    Reset mid-transfer abandons the word; no partial resume.
//  - host_ack passes through SYNC_STAGES flops to give ack_s. Only ack_s is used by the FSM.
//  - NUM_BYTES = DATA_W/BYTE_W. Bytes are sent LSB first: byte k = result[k*BYTE_W +: BYTE_W].
//  - FSM (all outputs registered):
//    S_IDLE: on result_valid -> capture result into shift reg, byte_cnt<=0, go to S_PRESENT.
//      out_valid=1, unloader_busy=1 and out_pins=byte0 appear the cycle after the strobe
//      (latency 1).
//    S_PRESENT: wait for ack_s==1, then out_valid<=0 and go to S_WAIT_LOW. out_pins is held.
//    S_WAIT_LOW: wait for ack_s==0.
//      If this is the last byte: go to S_IDLE, unloader_busy<=0, out_pins<=0.
//      Otherwise: shift right by BYTE_W, byte_cnt++, out_valid<=1, go to S_PRESENT.
//    Any unused encoding -> S_IDLE.
//  - result_valid is accepted only while the registered state is S_IDLE.
//    A strobe in any other state is dropped and sets overrun. This includes the cycle in which the
//    final ack-low returns the FSM to S_IDLE.
//  - overrun clears on the next accepted capture. It is not cleared by host activity.
//  - ack_s already high on entry to S_PRESENT (host violates protocol): treat as ack; no lockup.
//  - No timeout; the FSM waits indefinitely for the host.
//  - Signedness: the result is sent as a raw two's-complement bit pattern; no width conversion.
// CONFIGURATION
//  RESULT_UNLOADER_CHECKSUM_EN
//  - Defined: after the last data byte, one extra byte is sent with the same handshake:
//    the XOR of all NUM_BYTES data bytes.
//    The XOR is computed at capture time. The transfer is NUM_BYTES+1 bytes, and
//    unloader_busy drops only after that byte's ack-low.
//  - Undefined: exactly NUM_BYTES bytes; no checksum logic is built.
// STRUCTURE
//  - watchdog_pkg: the unloader state enum typedef (S_IDLE, S_PRESENT, S_WAIT_LOW) and
//    default-width localparams shared with the parameter-load path.
//  - Sub-module sync_bit (width 1, SYNC_STAGES flops, async reset to 0) for host_ack.
//    It is reusable for other pin inputs.
//  - The FSM, shift register, byte counter and overrun flag are inline.
// TESTING
//  1. Reset release, no stimulus -> out_valid=0, unloader_busy=0, out_pins=0, overrun=0 for 100 cycles.
//  2. result=32'h1234_5678 strobed, host acks each byte after 3 cycles ->
//     out_pins sequence 78,56,34,12; busy drops after the 4th ack-low.
//  3. result=-1 (32'hFFFF_FFFF) -> four bytes FF; with checksum enabled a fifth byte 00.
//     result=32'h0102_0408 with checksum -> 08,04,02,01,0F.
//  4. Second strobe during the byte-1 handshake -> overrun=1; transfer of the first word unaffected.
//     Next accepted strobe clears overrun.
//  5. Assert rst_n low after byte 2 is acked -> all outputs 0 immediately.
//     A fresh strobe after reset sends byte 0 of the new word.
//  6. Hold host_ack high before the strobe -> byte0 completes after ack falls; no hang, correct order.

Source files
------------

// File: rtl/watchdog_pkg.sv
// rtl/watchdog_pkg.sv - shared types and default widths for the watchdog pin interface
// Contents: unloader_state_t (S_IDLE, S_PRESENT, S_WAIT_LOW) and default-width localparams
// used by both the result return path and the parameter-load path.
package watchdog_pkg;

    localparam int DEFAULT_DATA_W      = 32;
    localparam int DEFAULT_BYTE_W      = 8;
    localparam int DEFAULT_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PRESENT  = 2'd1,
        S_WAIT_LOW = 2'd2
    } unloader_state_t;

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - single-bit multi-flop synchronizer for asynchronous pin inputs
// Ports:
//   clk    in  1  destination clock
//   rst_n  in  1  asynchronous active-low reset; clears the chain to 0
//   d      in  1  asynchronous input level
//   q      out 1  synchronized level, STAGES clocks behind d
// Parameters: STAGES (>=2) number of flops in the chain.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/result_unloader.sv
// rtl/result_unloader.sv - sends the core's 32-bit result to the host byte by byte over pins
// Ports:
//   clk            in  1       clock
//   rst_n          in  1       asynchronous active-low reset
//   result         in  DATA_W  signed core result, captured when a strobe is accepted
//   result_valid   in  1       one-cycle capture strobe from the core
//   unloader_busy  out 1       transfer in progress
//   out_pins       out BYTE_W  byte currently offered to the host (LSB byte first)
//   out_valid      out 1       byte available; four-phase handshake with host_ack
//   host_ack       in  1       asynchronous host acknowledge level
//   overrun        out 1       sticky: strobe dropped while not idle; cleared by next capture
// Build option: RESULT_UNLOADER_CHECKSUM_EN appends an XOR-of-data-bytes byte to each transfer.
module result_unloader
    import watchdog_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int BYTE_W      = DEFAULT_BYTE_W,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] result,
    input  logic                     result_valid,
    output logic                     unloader_busy,
    output logic [BYTE_W-1:0]        out_pins,
    output logic                     out_valid,
    input  logic                     host_ack,
    output logic                     overrun
);

    localparam int NUM_BYTES = DATA_W / BYTE_W;
`ifdef RESULT_UNLOADER_CHECKSUM_EN
    localparam int TOTAL_BYTES = NUM_BYTES + 1;
`else
    localparam int TOTAL_BYTES = NUM_BYTES;
`endif
    localparam int SHIFT_W = TOTAL_BYTES * BYTE_W;
    localparam int CNT_W   = $clog2(TOTAL_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL_BYTES - 1);

    logic ack_s;

    sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (host_ack),
        .q    (ack_s)
    );

    unloader_state_t     state_q, state_d;
    logic [SHIFT_W-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                overrun_q, overrun_d;
    logic [SHIFT_W-1:0]  capture_word;

`ifdef RESULT_UNLOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum;

    always_comb begin
        csum = '0;
        for (int k = 0; k < NUM_BYTES; k++) begin
            csum = csum ^ result[k*BYTE_W +: BYTE_W];
        end
    end

    // Checksum rides above the data so the right shift delivers it last.
    assign capture_word = {csum, result};
`else
    assign capture_word = result;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        overrun_d = overrun_q;

        // Acceptance depends on the registered state only, so the cycle that
        // returns to S_IDLE still drops a strobe.
        if (result_valid && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (result_valid) begin
                    shift_d   = capture_word;
                    cnt_d     = '0;
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                    overrun_d = 1'b0;
                    state_d   = S_PRESENT;
                end
            end
            S_PRESENT: begin
                // An ack already high on entry is taken as the acknowledge.
                if (ack_s) begin
                    valid_d = 1'b0;
                    state_d = S_WAIT_LOW;
                end
            end
            S_WAIT_LOW: begin
                if (!ack_s) begin
                    if (cnt_q == LAST_CNT) begin
                        shift_d = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        shift_d = shift_q >> BYTE_W;
                        cnt_d   = cnt_q + CNT_W'(1);
                        valid_d = 1'b1;
                        state_d = S_PRESENT;
                    end
                end
            end
            default: begin
                shift_d = '0;
                cnt_d   = '0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign out_pins      = shift_q[BYTE_W-1:0];
    assign out_valid     = valid_q;
    assign unloader_busy = busy_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_result_unloader.sv
// tb/tb_result_unloader.sv - randomized self-checking bench for result_unloader against a byte-queue model
module tb_result_unloader;

    localparam int NB = 4;
`ifdef RESULT_UNLOADER_CHECKSUM_EN
    localparam int TOTAL = NB + 1;
`else
    localparam int TOTAL = NB;
`endif

    logic               clk;
    logic               rst_n;
    logic signed [31:0] result;
    logic               result_valid;
    logic               unloader_busy;
    logic [7:0]         out_pins;
    logic               out_valid;
    logic               host_ack;
    logic               overrun;

    result_unloader #(
        .DATA_W     (32),
        .BYTE_W     (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .result       (result),
        .result_valid (result_valid),
        .unloader_busy(unloader_busy),
        .out_pins     (out_pins),
        .out_valid    (out_valid),
        .host_ack     (host_ack),
        .overrun      (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: a queue of bytes the host must still receive, plus
    // the expected overrun flag and whether a transfer is outstanding.
    logic [7:0] exp_q[$];
    logic [7:0] seen_q[$];
    logic       model_busy  = 1'b0;
    logic       exp_overrun = 1'b0;

    initial begin
        logic [7:0] b;
        logic [7:0] cs;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                exp_q.delete();
                model_busy  = 1'b0;
                exp_overrun = 1'b0;
            end else if (result_valid) begin
                if (model_busy) begin
                    exp_overrun = 1'b1;
                end else begin
                    cs = 8'h00;
                    for (int k = 0; k < NB; k++) begin
                        b = result[k*8 +: 8];
                        exp_q.push_back(b);
                        cs = cs ^ b;
                    end
`ifdef RESULT_UNLOADER_CHECKSUM_EN
                    exp_q.push_back(cs);
`endif
                    model_busy  = 1'b1;
                    exp_overrun = 1'b0;
                end
            end
        end
    end

    // Compare process: every falling edge.
    initial begin
        logic       prev_ov;
        logic       prev_busy;
        logic [7:0] cur;
        logic [7:0] e;
        prev_ov   = 1'b0;
        prev_busy = 1'b0;
        cur       = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("reset_outputs", {21'd0, out_valid, unloader_busy, overrun, out_pins}, 32'd0);
                prev_ov   = 1'b0;
                prev_busy = 1'b0;
            end else begin
                if (out_valid && !prev_ov) begin
                    check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("byte_value", {24'd0, out_pins}, {24'd0, e});
                        cur = e;
                        seen_q.push_back(out_pins);
                    end
                end else if (out_valid) begin
                    check("pins_stable", {24'd0, out_pins}, {24'd0, cur});
                end
                if (out_valid) check("busy_with_valid", {31'd0, unloader_busy}, 32'd1);
                if (prev_busy && !unloader_busy) check("bytes_left_at_idle", 32'(exp_q.size()), 32'd0);
                if (!model_busy) check("idle_outputs", {22'd0, out_valid, unloader_busy, out_pins}, 32'd0);
                check("overrun", {31'd0, overrun}, {31'd0, exp_overrun});
                prev_ov   = out_valid;
                prev_busy = unloader_busy;
            end
        end
    end

    // Host: four-phase responder with random or fixed delays.
    logic host_en   = 1'b0;
    logic fixed_dly = 1'b0;

    initial begin
        int hstate;
        int hcnt;
        hstate = 0;
        hcnt   = 0;
        forever begin
            @(negedge clk);
            if (!host_en || !rst_n) begin
                hstate = 0;
            end else begin
                case (hstate)
                    0: if (out_valid) begin
                        hcnt   = fixed_dly ? 3 : int'($urandom_range(0, 3));
                        hstate = 1;
                    end
                    1: if (hcnt <= 1) begin
                        host_ack = 1'b1;
                        hstate   = 2;
                    end else hcnt--;
                    2: if (!out_valid) begin
                        hcnt   = fixed_dly ? 3 : int'($urandom_range(0, 3));
                        hstate = 3;
                    end
                    default: if (hcnt <= 1) begin
                        host_ack = 1'b0;
                        hstate   = 0;
                    end else hcnt--;
                endcase
            end
        end
    end

    task automatic strobe(input logic [31:0] v);
        logic accept;
        @(negedge clk);
        accept       = !model_busy;
        result       = v;
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        result       = $urandom;
        if (accept) begin
            check("latency1_valid", {31'd0, out_valid}, 32'd1);
            check("latency1_byte0", {24'd0, out_pins}, {24'd0, v[7:0]});
        end
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!unloader_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_reached", {31'd0, ok}, 32'd1);
        model_busy = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_byte_shown(input int remaining);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (exp_q.size() == remaining && out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("byte_shown_wait", {31'd0, ok}, 32'd1);
    endtask

    task automatic check_seen(input string name, input logic [39:0] lit);
        check({name, "_count"}, 32'(seen_q.size()), TOTAL);
        for (int i = 0; i < TOTAL; i++) begin
            if (i < seen_q.size()) check(name, {24'd0, seen_q[i]}, {24'd0, lit[i*8 +: 8]});
        end
    endtask

    initial begin
        logic [31:0] v;
        logic        ok;
        rst_n        = 1'b0;
        result       = '0;
        result_valid = 1'b0;
        host_ack     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        host_en = 1'b1;

        // Idle after reset release.
        repeat (100) @(negedge clk);
        check("idle_after_reset", {22'd0, out_valid, unloader_busy, out_pins}, 32'd0);

        // Fixed 3-cycle host, known word.
        fixed_dly = 1'b1;
        seen_q.delete();
        strobe(32'h1234_5678);
        wait_idle();
        check_seen("seq_12345678", 40'h08_1234_5678);
        fixed_dly = 1'b0;

        // All-ones and a checksum-visible pattern.
        seen_q.delete();
        strobe(32'hFFFF_FFFF);
        wait_idle();
        check_seen("seq_minus1", 40'h00_FFFF_FFFF);
        seen_q.delete();
        strobe(32'h0102_0408);
        wait_idle();
        check_seen("seq_01020408", 40'h0F_0102_0408);

        // Overrun during byte-1 handshake, then cleared by next capture.
        strobe(32'hA5C3_0F96);
        wait_byte_shown(TOTAL - 2);
        strobe(32'hDEAD_BEEF);
        wait_idle();
        check("overrun_sticky", {31'd0, overrun}, 32'd1);
        strobe(32'h0000_0001);
        wait_idle();
        check("overrun_cleared", {31'd0, overrun}, 32'd0);

        // Reset mid-transfer after the second byte is acked.
        strobe(32'h7766_5544);
        wait_byte_shown(TOTAL - 2);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("byte1_acked", {31'd0, ok}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {21'd0, out_valid, unloader_busy, overrun, out_pins}, 32'd0);
        host_en  = 1'b0;
        host_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        host_en = 1'b1;
        seen_q.delete();
        strobe(32'h8899_AABB);
        wait_idle();
        check_seen("seq_after_reset", 40'h00_8899_AABB ^ 40'h0000_0000 | {8'h88 ^ 8'h99 ^ 8'hAA ^ 8'hBB, 32'h0});

        // Host holds ack high before the strobe.
        host_en  = 1'b0;
        host_ack = 1'b1;
        repeat (5) @(negedge clk);
        seen_q.delete();
        strobe(32'hCAFE_F00D);
        repeat (10) @(negedge clk);
        check("ack_high_waits_low", {30'd0, out_valid, unloader_busy}, 32'd1);
        host_ack = 1'b0;
        host_en  = 1'b1;
        wait_idle();
        check_seen("seq_ack_high", {8'hCA ^ 8'hFE ^ 8'hF0 ^ 8'h0D, 32'hCAFE_F00D});

        // Randomized words, delays and overrun strobes.
        for (int n = 0; n < 30; n++) begin
            v = $urandom;
            strobe(v);
            if ($urandom_range(0, 2) == 0) begin
                wait_byte_shown(int'($urandom_range(0, TOTAL - 1)));
                strobe($urandom);
            end
            wait_idle();
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
